// File: rtl/user_cmd_engine.sv
// user_cmd_engine: serial command engine between a UART byte stream and an
// SDRAM byte-access port. It parses framed host commands
// ('!' opcode, length, address[, pattern]) and runs SDRAM burst reads,
// writes and fills. It also returns a version string and status bytes.
//
// Optional feature: define USER_CMD_CHECKSUM_EN to keep an 8-bit running sum
// of the data bytes. A read then sends the sum after its data. Write and fill
// statuses are then followed by the sum byte.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   uart_rxd/_strobe     received byte and its one-cycle valid
//   uart_txd/_strobe     byte to transmit and its one-cycle pulse
//   uart_txd_ready       transmitter can accept a byte
//   sd_addr, sd_wr_data  SDRAM byte address and write data
//   sd_rd_data, sd_ack   SDRAM read data and one-cycle access completion
//   sd_idle              SDRAM controller can accept a request
//   sd_we, sd_enable     write select and access request (held until sd_ack)
//   busy                 high whenever the engine is not in WAIT
module user_cmd_engine #(
  parameter int unsigned ADDR_BITS      = 32,
  parameter int unsigned ADDR_BYTES     = 4,
  parameter int unsigned LEN_BYTES      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [63:0] VERSION_STR    = "spispy01"
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           uart_rxd,
  input  logic                 uart_rxd_strobe,
  output logic [7:0]           uart_txd,
  output logic                 uart_txd_strobe,
  input  logic                 uart_txd_ready,
  output logic [ADDR_BITS-1:0] sd_addr,
  output logic [7:0]           sd_wr_data,
  input  logic [7:0]           sd_rd_data,
  input  logic                 sd_ack,
  input  logic                 sd_idle,
  output logic                 sd_we,
  output logic                 sd_enable,
  output logic                 busy
);

  localparam int unsigned LEN_W = 8 * LEN_BYTES;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned HDR_W = 3;

  localparam logic [7:0] CH_BANG  = 8'h21;  // '!'
  localparam logic [7:0] CH_R     = 8'h52;  // 'R'
  localparam logic [7:0] CH_W     = 8'h57;  // 'W'
  localparam logic [7:0] CH_F     = 8'h46;  // 'F'
  localparam logic [7:0] CH_V     = 8'h56;  // 'V'
  localparam logic [7:0] CH_QUES  = 8'h3F;  // '?'
  localparam logic [7:0] CH_PCT   = 8'h25;  // '%'
  localparam logic [7:0] CH_W_LC  = 8'h77;  // 'w'
  localparam logic [7:0] CH_F_LC  = 8'h66;  // 'f'
  localparam logic [7:0] CH_T     = 8'h54;  // 'T'

  typedef enum logic [3:0] {
    WAIT, OPC, LEN, ADDR, PAT, RD_REQ, RD_WAIT, RD_TX,
    WR_RX, WR_REQ, WR_WAIT, VER, STATUS
  } state_e;

  state_e             state_q;
  logic [LEN_W-1:0]   len_q;
  logic [TMO_W-1:0]   tmo_q;
  logic [HDR_W-1:0]   hcnt_q;
  logic [2:0]         ver_idx_q;
  logic [7:0]         opc_q;
  logic [7:0]         status_q;
  logic               ovr_q;
`ifdef USER_CMD_CHECKSUM_EN
  logic [7:0]         csum_q;
  logic               sum_pend_q;
`endif

  // Header field shifting, burst stepping and tx flow control
  logic [ADDR_BITS-1:0] addr_shift;
  logic [ADDR_BITS-1:0] addr_inc;
  logic [LEN_W-1:0]     len_shift;
  logic [LEN_W-1:0]     len_dec;
  logic                 tx_ok;
  logic                 tmo_st;
  logic                 tmo_hit;
  logic                 is_fill;

  assign addr_shift = ADDR_BITS'({sd_addr, uart_rxd});
  assign addr_inc   = sd_addr + ADDR_BITS'(1);
  assign len_shift  = LEN_W'({len_q, uart_rxd});
  // Saturating decrement: the length counter never underflows
  assign len_dec    = (len_q != '0) ? len_q - LEN_W'(1) : len_q;
  // A strobe is never issued two cycles in a row
  assign tx_ok      = uart_txd_ready & ~uart_txd_strobe;
  assign tmo_st     = (state_q == OPC) || (state_q == LEN) || (state_q == ADDR) ||
                      (state_q == PAT) || (state_q == WR_RX);
  assign tmo_hit    = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign is_fill    = (opc_q == CH_F);

  // Main engine FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= WAIT;
      len_q           <= '0;
      tmo_q           <= '0;
      hcnt_q          <= '0;
      ver_idx_q       <= '0;
      opc_q           <= '0;
      status_q        <= '0;
      ovr_q           <= 1'b0;
      uart_txd        <= '0;
      uart_txd_strobe <= 1'b0;
      sd_addr         <= '0;
      sd_wr_data      <= '0;
      sd_we           <= 1'b0;
      sd_enable       <= 1'b0;
      busy            <= 1'b0;
`ifdef USER_CMD_CHECKSUM_EN
      csum_q          <= '0;
      sum_pend_q      <= 1'b0;
`endif
    end else begin
      uart_txd_strobe <= 1'b0;

      // Inter-byte timeout only runs while a frame or write payload is pending
      if (uart_rxd_strobe || !tmo_st) begin
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_q + TMO_W'(1);
      end

      case (state_q)
        WAIT: begin
          if (uart_rxd_strobe) begin
            busy <= 1'b1;
            if (uart_rxd == CH_BANG) begin
              state_q <= OPC;
              sd_addr <= '0;
              len_q   <= '0;
              ovr_q   <= 1'b0;
`ifdef USER_CMD_CHECKSUM_EN
              csum_q  <= '0;
`endif
            end else begin
              // Resync hint for the host
              status_q <= CH_BANG;
              state_q  <= STATUS;
`ifdef USER_CMD_CHECKSUM_EN
              sum_pend_q <= 1'b0;
`endif
            end
          end
        end

        OPC: begin
          if (uart_rxd_strobe) begin
            if (uart_rxd == CH_R || uart_rxd == CH_W || uart_rxd == CH_F) begin
              opc_q   <= uart_rxd;
              hcnt_q  <= '0;
              state_q <= LEN;
            end else if (uart_rxd == CH_V) begin
              ver_idx_q <= '0;
              state_q   <= VER;
            end else begin
              status_q <= CH_QUES;
              state_q  <= STATUS;
`ifdef USER_CMD_CHECKSUM_EN
              sum_pend_q <= 1'b0;
`endif
            end
          end else if (tmo_hit) begin
            status_q <= CH_T;
            state_q  <= STATUS;
`ifdef USER_CMD_CHECKSUM_EN
            sum_pend_q <= 1'b0;
`endif
          end
        end

        LEN: begin
          if (uart_rxd_strobe) begin
            len_q <= len_shift;
            if (hcnt_q == HDR_W'(LEN_BYTES - 1)) begin
              hcnt_q  <= '0;
              state_q <= ADDR;
            end else begin
              hcnt_q <= hcnt_q + HDR_W'(1);
            end
          end else if (tmo_hit) begin
            status_q <= CH_T;
            state_q  <= STATUS;
`ifdef USER_CMD_CHECKSUM_EN
            sum_pend_q <= 1'b0;
`endif
          end
        end

        ADDR: begin
          if (uart_rxd_strobe) begin
            sd_addr <= addr_shift;
            if (hcnt_q == HDR_W'(ADDR_BYTES - 1)) begin
              hcnt_q <= '0;
              if (is_fill) begin
                state_q <= PAT;
              end else if (len_q == '0) begin
                // Empty read ends silently; empty write still reports
                if (opc_q == CH_R) begin
                  state_q <= WAIT;
                  busy    <= 1'b0;
                end else begin
                  status_q <= CH_W_LC;
                  state_q  <= STATUS;
`ifdef USER_CMD_CHECKSUM_EN
                  sum_pend_q <= 1'b1;
`endif
                end
              end else if (opc_q == CH_R) begin
                state_q <= RD_REQ;
              end else begin
                state_q <= WR_RX;
              end
            end else begin
              hcnt_q <= hcnt_q + HDR_W'(1);
            end
          end else if (tmo_hit) begin
            status_q <= CH_T;
            state_q  <= STATUS;
`ifdef USER_CMD_CHECKSUM_EN
            sum_pend_q <= 1'b0;
`endif
          end
        end

        PAT: begin
          if (uart_rxd_strobe) begin
            sd_wr_data <= uart_rxd;
            if (len_q == '0) begin
              status_q <= CH_F_LC;
              state_q  <= STATUS;
`ifdef USER_CMD_CHECKSUM_EN
              sum_pend_q <= 1'b1;
`endif
            end else begin
              state_q <= WR_REQ;
            end
          end else if (tmo_hit) begin
            status_q <= CH_T;
            state_q  <= STATUS;
`ifdef USER_CMD_CHECKSUM_EN
            sum_pend_q <= 1'b0;
`endif
          end
        end

        // Only request a read once the transmitter can take the result
        RD_REQ: begin
          if (sd_idle && uart_txd_ready) begin
            sd_enable <= 1'b1;
            sd_we     <= 1'b0;
            state_q   <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          if (sd_ack) begin
            sd_enable <= 1'b0;
            uart_txd  <= sd_rd_data;
            state_q   <= RD_TX;
          end
        end

        RD_TX: begin
          if (tx_ok) begin
            uart_txd_strobe <= 1'b1;
            sd_addr         <= addr_inc;
            len_q           <= len_dec;
`ifdef USER_CMD_CHECKSUM_EN
            csum_q          <= csum_q + uart_txd;
`endif
            if (len_dec == '0) begin
`ifdef USER_CMD_CHECKSUM_EN
              status_q   <= csum_q + uart_txd;
              sum_pend_q <= 1'b0;
              state_q    <= STATUS;
`else
              state_q    <= WAIT;
              busy       <= 1'b0;
`endif
            end else begin
              state_q <= RD_REQ;
            end
          end
        end

        WR_RX: begin
          if (uart_rxd_strobe) begin
            sd_wr_data <= uart_rxd;
            state_q    <= WR_REQ;
          end else if (tmo_hit) begin
            status_q <= CH_T;
            state_q  <= STATUS;
`ifdef USER_CMD_CHECKSUM_EN
            sum_pend_q <= 1'b0;
`endif
          end
        end

        WR_REQ: begin
          if (uart_rxd_strobe) begin
            ovr_q <= 1'b1;
          end
          if (sd_idle) begin
            sd_enable <= 1'b1;
            sd_we     <= 1'b1;
            state_q   <= WR_WAIT;
          end
        end

        // A byte arriving together with the ack still counts as overrun
        WR_WAIT: begin
          if (sd_ack) begin
            sd_enable <= 1'b0;
            sd_we     <= 1'b0;
            sd_addr   <= addr_inc;
            len_q     <= len_dec;
`ifdef USER_CMD_CHECKSUM_EN
            csum_q    <= csum_q + sd_wr_data;
`endif
            if (ovr_q || uart_rxd_strobe) begin
              status_q <= CH_PCT;
              state_q  <= STATUS;
`ifdef USER_CMD_CHECKSUM_EN
              sum_pend_q <= 1'b1;
`endif
            end else if (len_dec == '0) begin
              status_q <= is_fill ? CH_F_LC : CH_W_LC;
              state_q  <= STATUS;
`ifdef USER_CMD_CHECKSUM_EN
              sum_pend_q <= 1'b1;
`endif
            end else if (is_fill) begin
              state_q <= WR_REQ;
            end else begin
              state_q <= WR_RX;
            end
          end else if (uart_rxd_strobe) begin
            ovr_q <= 1'b1;
          end
        end

        // Version string is sent first character first (MSB byte first)
        VER: begin
          if (tx_ok) begin
            uart_txd        <= VERSION_STR[{3'd7 - ver_idx_q, 3'b000} +: 8];
            uart_txd_strobe <= 1'b1;
            ver_idx_q       <= ver_idx_q + 3'd1;
            if (ver_idx_q == 3'd7) begin
              state_q <= WAIT;
              busy    <= 1'b0;
            end
          end
        end

        STATUS: begin
          if (tx_ok) begin
            uart_txd        <= status_q;
            uart_txd_strobe <= 1'b1;
`ifdef USER_CMD_CHECKSUM_EN
            if (sum_pend_q) begin
              status_q   <= csum_q;
              sum_pend_q <= 1'b0;
            end else begin
              state_q <= WAIT;
              busy    <= 1'b0;
            end
`else
            state_q <= WAIT;
            busy    <= 1'b0;
`endif
          end
        end

        default: begin
          state_q   <= WAIT;
          sd_enable <= 1'b0;
          sd_we     <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_user_cmd_engine.sv
// Scoreboard bench for user_cmd_engine: expected tx bytes and SDRAM accesses
// are queued as commands are driven and popped as the DUT produces them.
module tb_user_cmd_engine;

  localparam int unsigned TMO = 50;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  uart_rxd;
  logic        uart_rxd_strobe;
  logic [7:0]  uart_txd;
  logic        uart_txd_strobe;
  logic        uart_txd_ready;
  logic [31:0] sd_addr;
  logic [7:0]  sd_wr_data;
  logic [7:0]  sd_rd_data;
  logic        sd_ack;
  logic        sd_idle;
  logic        sd_we;
  logic        sd_enable;
  logic        busy;

  logic        hold_ack = 1'b0;
  int          checks = 0;
  int          errors = 0;

  logic [7:0]  exp_tx[$];
  logic [40:0] exp_acc[$];  // {we, addr, data}
  logic [7:0]  mem [logic [31:0]];

  user_cmd_engine #(
    .ADDR_BITS(32), .ADDR_BYTES(4), .LEN_BYTES(3),
    .TIMEOUT_CYCLES(TMO), .VERSION_STR("spispy01")
  ) dut (
    .clk(clk), .reset(reset),
    .uart_rxd(uart_rxd), .uart_rxd_strobe(uart_rxd_strobe),
    .uart_txd(uart_txd), .uart_txd_strobe(uart_txd_strobe),
    .uart_txd_ready(uart_txd_ready),
    .sd_addr(sd_addr), .sd_wr_data(sd_wr_data), .sd_rd_data(sd_rd_data),
    .sd_ack(sd_ack), .sd_idle(sd_idle), .sd_we(sd_we),
    .sd_enable(sd_enable), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Transmitter model and tx scoreboard: ready drops for a few cycles per byte
  initial begin
    logic prev;
    int   hold;
    prev = 1'b0;
    hold = 0;
    uart_txd_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (uart_txd_strobe) begin
        check("tx_ready", 64'(uart_txd_ready), 64'd1);
        check("tx_gap", 64'(prev), 64'd0);
        if (exp_tx.size() == 0) check("tx_extra", 64'(exp_tx.size()), 64'd1);
        else check("tx_byte", 64'(uart_txd), 64'(exp_tx.pop_front()));
        uart_txd_ready = 1'b0;
        hold = 3;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) uart_txd_ready = 1'b1;
      end
      prev = uart_txd_strobe;
    end
  end

  // SDRAM model: acks two cycles after a request, checks each access
  initial begin
    int          lat;
    logic [40:0] e;
    lat = 0;
    sd_ack = 1'b0;
    sd_rd_data = 8'h00;
    sd_idle = 1'b1;
    forever begin
      @(negedge clk);
      sd_ack = 1'b0;
      if (sd_enable && !hold_ack && !reset) begin
        lat++;
        if (lat >= 2) begin
          lat = 0;
          sd_ack = 1'b1;
          if (exp_acc.size() == 0) check("acc_extra", 64'(exp_acc.size()), 64'd1);
          else begin
            e = exp_acc.pop_front();
            check("acc_we", 64'(sd_we), 64'(e[40]));
            check("acc_addr", 64'(sd_addr), 64'(e[39:8]));
            if (sd_we) check("acc_data", 64'(sd_wr_data), 64'(e[7:0]));
          end
          if (sd_we) mem[sd_addr] = sd_wr_data;
          else sd_rd_data = mem.exists(sd_addr) ? mem[sd_addr] : 8'h00;
        end
      end else begin
        lat = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] b, input int gap);
    @(negedge clk);
    uart_rxd = b;
    uart_rxd_strobe = 1'b1;
    @(negedge clk);
    uart_rxd_strobe = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_hdr(input logic [7:0] opc, input logic [23:0] len, input logic [31:0] addr);
    send(8'h21, 1);
    send(opc, 1);
    for (int i = 2; i >= 0; i--) send(len[8*i +: 8], 1);
    for (int i = 3; i >= 0; i--) send(addr[8*i +: 8], 1);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_tx.size() != 0 || exp_acc.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_txq"}, 64'(exp_tx.size()), 64'd0);
    check({tag, "_accq"}, 64'(exp_acc.size()), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    logic [63:0] ver;
    int          n;
    reset = 1'b1;
    uart_rxd = 8'h00;
    uart_rxd_strobe = 1'b0;
    mem[32'h10] = 8'hAA;
    mem[32'h11] = 8'hBB;
    mem[32'h12] = 8'hCC;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_txs", 64'(uart_txd_strobe), 64'd0);
    check("rst_txd", 64'(uart_txd), 64'd0);
    check("rst_en", 64'(sd_enable), 64'd0);
    check("rst_we", 64'(sd_we), 64'd0);
    check("rst_addr", 64'(sd_addr), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Version
    ver = "spispy01";
    for (int i = 7; i >= 0; i--) exp_tx.push_back(ver[8*i +: 8]);
    send(8'h21, 1);
    send(8'h56, 0);
    drain("ver");

    // Burst read
    for (int i = 0; i < 3; i++) exp_acc.push_back({1'b0, 32'h10 + 32'(i), 8'h00});
    exp_tx.push_back(8'hAA); exp_tx.push_back(8'hBB); exp_tx.push_back(8'hCC);
`ifdef USER_CMD_CHECKSUM_EN
    exp_tx.push_back(8'h31);
`endif
    send_hdr(8'h52, 24'd3, 32'h10);
    drain("read");

    // Burst write with gaps between payload bytes
    exp_acc.push_back({1'b1, 32'h100, 8'h55});
    exp_acc.push_back({1'b1, 32'h101, 8'h66});
    exp_tx.push_back(8'h77);
`ifdef USER_CMD_CHECKSUM_EN
    exp_tx.push_back(8'hBB);
`endif
    send_hdr(8'h57, 24'd2, 32'h100);
    send(8'h55, 12);
    send(8'h66, 12);
    drain("write");
    check("mem_101", 64'(mem[32'h101]), 64'h66);

    // Fill across the address wrap
    exp_acc.push_back({1'b1, 32'hFFFF_FFFE, 8'h5A});
    exp_acc.push_back({1'b1, 32'hFFFF_FFFF, 8'h5A});
    exp_acc.push_back({1'b1, 32'h0000_0000, 8'h5A});
    exp_acc.push_back({1'b1, 32'h0000_0001, 8'h5A});
    exp_tx.push_back(8'h66);
`ifdef USER_CMD_CHECKSUM_EN
    exp_tx.push_back(8'h68);
`endif
    send_hdr(8'h46, 24'd4, 32'hFFFF_FFFE);
    send(8'h5A, 0);
    drain("fill");

    // Overrun: second byte arrives while the first write is outstanding
    exp_acc.push_back({1'b1, 32'h200, 8'h11});
    exp_tx.push_back(8'h25);
`ifdef USER_CMD_CHECKSUM_EN
    exp_tx.push_back(8'h11);
`endif
    hold_ack = 1'b1;
    send_hdr(8'h57, 24'd2, 32'h200);
    send(8'h11, 3);
    send(8'h22, 5);
    hold_ack = 1'b0;
    drain("ovr");

    // Unknown opcode, then stray byte in WAIT
    exp_tx.push_back(8'h3F);
    send(8'h21, 1);
    send(8'h51, 0);
    drain("badop");
    exp_tx.push_back(8'h21);
    send(8'h78, 0);
    drain("resync");

    // Empty read returns silently; empty write still reports
    exp_tx.push_back(8'h77);
`ifdef USER_CMD_CHECKSUM_EN
    exp_tx.push_back(8'h00);
`endif
    send_hdr(8'h52, 24'd0, 32'h10);
    send_hdr(8'h57, 24'd0, 32'h10);
    drain("zero");

    // Incomplete frame times out
    exp_tx.push_back(8'h54);
    send(8'h21, 1);
    send(8'h52, 0);
    drain("tmo");

    // Reset while a read access is outstanding
    hold_ack = 1'b1;
    send_hdr(8'h52, 24'd3, 32'h10);
    n = 0;
    while (!sd_enable && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("mid_en_seen", 64'(sd_enable), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_en", 64'(sd_enable), 64'd0);
    check("mid_busy", 64'(busy), 64'd0);
    check("mid_addr", 64'(sd_addr), 64'd0);
    reset = 1'b0;
    hold_ack = 1'b0;
    repeat (30) @(negedge clk);
    drain("mid");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
